// File: rtl/life_frame_reader_pkg.sv
// Shared sizes and FSM encoding for the life frame reader.
// Imported by the reader top and its row serializer.
package life_frame_reader_pkg;

  localparam int LIFE_ROWS  = 16;
  localparam int LIFE_COLS  = 16;
  localparam int LIFE_SEL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_LOAD,
    S_SHIFT,
    S_STEP,
    S_DONE
  } state_t;

endpackage

// File: rtl/life_row_serializer.sv
// Row load/shift register with column counter.
// Streams one captured row MSB first over a valid/ready handshake.
import life_frame_reader_pkg::*;

module life_row_serializer #(
  parameter int COLS = LIFE_COLS,
  parameter int CW   = LIFE_SEL_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            active,
  input  logic [COLS-1:0] row_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            out_bit,
  output logic [CW-1:0]   out_col,
  output logic            row_end
);

  logic [COLS-1:0] shreg;
  logic [CW-1:0]   col;
  logic            fire;
  logic            col_last;

  assign fire      = active & out_ready;
  assign col_last  = (col == CW'(COLS - 1));
  assign row_end   = fire & col_last;
  assign out_valid = active;
  assign out_bit   = shreg[COLS-1];
  assign out_col   = col;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
      col   <= '0;
    end else if (load) begin
      shreg <= row_data;
      col   <= '0;
    end else if (fire) begin
      shreg <= {shreg[COLS-2:0], 1'b0};
      if (!col_last) begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/life_frame_reader.sv
// Sweeps the life array row by row and streams every cell out.
// Tracks generation change and optionally steps the array after.
import life_frame_reader_pkg::*;

module life_frame_reader #(
  parameter int ROWS  = LIFE_ROWS,
  parameter int COLS  = LIFE_COLS,
  parameter int SEL_W = LIFE_SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_step,
  output logic             busy,
  output logic [SEL_W-1:0] row_sel,
  input  logic [COLS-1:0]  row_data,
  input  logic [COLS-1:0]  row_prev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SEL_W-1:0] out_row,
  output logic [SEL_W-1:0] out_col,
  output logic             out_last,
  output logic             step,
  output logic             frame_done,
  output logic             frame_changed
);

  state_t           state;
  state_t           nxt;
  logic [SEL_W-1:0] row;
  logic             auto_q;
  logic             changed;
  logic             row_end;
  logic             last_row;

  assign last_row = (row == SEL_W'(ROWS - 1));

  life_row_serializer #(
    .COLS (COLS),
    .CW   (SEL_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (state == S_LOAD),
    .active    (state == S_SHIFT),
    .row_data  (row_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_col   (out_col),
    .row_end   (row_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      row     <= '0;
      auto_q  <= 1'b0;
      changed <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        row     <= '0;
        auto_q  <= auto_step;
        changed <= 1'b0;
      end
      if (state == S_LOAD) begin
        changed <= changed | (|(row_data ^ row_prev));
      end
      if (row_end && !last_row) begin
        row <= row + SEL_W'(1);
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_SEL;
      S_SEL:   nxt = S_LOAD;
      S_LOAD:  nxt = S_SHIFT;
      S_SHIFT: begin
        if (row_end) begin
          if (!last_row)   nxt = S_SEL;
          else if (auto_q) nxt = S_STEP;
          else             nxt = S_DONE;
        end
      end
      S_STEP:  nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign row_sel       = row;
  assign out_row       = row;
  assign out_last      = out_valid & last_row &
                         (out_col == SEL_W'(COLS - 1));
  assign step          = (state == S_STEP);
  assign frame_done    = (state == S_DONE);
  assign frame_changed = changed;

endmodule

// File: tb/tb_life_frame_reader.sv
// Scoreboard bench for life_frame_reader.
// Expected cells are queued from the array model at start.
module tb_life_frame_reader;

  typedef struct packed {
    logic       b;
    logic [3:0] r;
    logic [3:0] c;
    logic       last;
  } cell_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        auto_step;
  logic        busy;
  logic [3:0]  row_sel;
  logic [15:0] row_data;
  logic [15:0] row_prev;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        step;
  logic        frame_done;
  logic        frame_changed;

  logic [15:0] cur [16];
  logic [15:0] prv [16];

  int    vectors = 0;
  int    errors  = 0;
  cell_t exp_q[$];
  cell_t obs_q[$];
  int    k_first, k_step, k_last_acc, k_done;
  int    n_steps, n_done, stall_viol;
  bit    done_seen, busy_late;
  logic  chg_at_done;
  logic  exp_chg;

  assign row_data = cur[row_sel];
  assign row_prev = prv[row_sel];

  always #5 clk = ~clk;

  life_frame_reader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .auto_step     (auto_step),
    .busy          (busy),
    .row_sel       (row_sel),
    .row_data      (row_data),
    .row_prev      (row_prev),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bit       (out_bit),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_last      (out_last),
    .step          (step),
    .frame_done    (frame_done),
    .frame_changed (frame_changed)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // glider moving (prev all empty) or block still-life (prev == cur)
  task automatic load_array(input bit still);
    for (int r = 0; r < 16; r++) begin
      cur[r] = 16'h0;
      prv[r] = 16'h0;
    end
    if (still) begin
      cur[5] = 16'h0180;
      cur[6] = 16'h0180;
      prv[5] = 16'h0180;
      prv[6] = 16'h0180;
    end else begin
      cur[1] = 16'h2000;
      cur[2] = 16'h1000;
      cur[3] = 16'h7000;
    end
    exp_chg = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if ((cur[r] ^ prv[r]) != 16'h0) exp_chg = 1'b1;
    end
  endtask

  task automatic push_expected();
    cell_t e;
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        e.b    = cur[r][15-c];
        e.r    = 4'(r);
        e.c    = 4'(c);
        e.last = (r == 15) && (c == 15);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input int pct, input bit auto,
                           input bit extra);
    logic [10:0] held;
    logic [10:0] now;
    bit          stalled;
    obs_q.delete();
    n_steps = 0; n_done = 0; stall_viol = 0;
    done_seen = 0; busy_late = 0; stalled = 0;
    k_first = -1; k_step = -1; k_last_acc = -1; k_done = -1;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    auto_step = auto;
    @(posedge clk);
    for (int k = 1; k <= 3000 && !done_seen; k++) begin
      @(negedge clk);
      start = extra && (k == 5 || k == 40);
      out_ready = ($urandom_range(99) < pct);
      now = {out_valid, out_bit, out_row, out_col, out_last};
      if (stalled && now !== held) stall_viol++;
      if (out_valid === 1'b1 && k_first < 0) k_first = k;
      if (step === 1'b1) begin
        n_steps++;
        k_step = k;
      end
      if (frame_done === 1'b1) begin
        n_done++;
        done_seen = 1;
        k_done = k;
        chg_at_done = frame_changed;
      end
      if (out_valid === 1'b1 && out_ready) begin
        obs_q.push_back({out_bit, out_row, out_col, out_last});
        k_last_acc = k;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = now;
    end
    start = extra && done_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (frame_done === 1'b1) n_done++;
      if (step === 1'b1) n_steps++;
      if (busy !== 1'b0) busy_late = 1;
    end
    out_ready = 1'b1;
    auto_step = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] v;
    reset = 1'b0;
    start = 1'b1;
    auto_step = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      v = {busy, out_valid, out_bit, out_last, step, frame_done,
           frame_changed, row_sel, out_row, out_col, 2'b00};
      vectors++;
      if (v !== 21'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0", v);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    auto_step = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({busy, out_valid, step} !== 3'b000) begin
        errors++;
        $display("FAIL idle_after_reset: got %b want 000",
                 {busy, out_valid, step});
      end
    end
  endtask

  task automatic test_glider();
    cell_t e, o;
    do_reset();
    load_array(1'b0);
    push_expected();
    run_frame(100, 1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != 256) begin
      errors++;
      $display("FAIL glider_count: got %0d want 256", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL glider_cell: got %h want %h", o, e);
      end
    end
    vectors++;
    if (k_first != 3) begin
      errors++;
      $display("FAIL first_latency: got %0d want 3", k_first);
    end
    vectors++;
    if (k_done != 289) begin
      errors++;
      $display("FAIL frame_cycles: got %0d want 289", k_done);
    end
    vectors++;
    if (n_steps != 0 || n_done != 1) begin
      errors++;
      $display("FAIL glider_pulses: got step %0d done %0d want 0 1",
               n_steps, n_done);
    end
    vectors++;
    if (chg_at_done !== exp_chg) begin
      errors++;
      $display("FAIL glider_changed: got %b want %b",
               chg_at_done, exp_chg);
    end
  endtask

  task automatic test_random_ready();
    cell_t e, o;
    do_reset();
    load_array(1'b0);
    push_expected();
    run_frame(50, 1'b0, 1'b0);
    vectors++;
    if (obs_q.size() != 256) begin
      errors++;
      $display("FAIL rand_count: got %0d want 256", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_cell: got %h want %h", o, e);
      end
    end
    vectors++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d want 0", stall_viol);
    end
    vectors++;
    if (!done_seen || n_done != 1) begin
      errors++;
      $display("FAIL rand_done: got %0d want 1", n_done);
    end
  endtask

  task automatic test_auto_step();
    do_reset();
    load_array(1'b0);
    run_frame(100, 1'b1, 1'b0);
    vectors++;
    if (n_steps != 1) begin
      errors++;
      $display("FAIL step_count: got %0d want 1", n_steps);
    end
    vectors++;
    if (!(k_step > k_last_acc && k_step < k_done)) begin
      errors++;
      $display("FAIL step_order: got step %0d acc %0d done %0d",
               k_step, k_last_acc, k_done);
    end
    vectors++;
    if (k_done != 290) begin
      errors++;
      $display("FAIL step_cycles: got %0d want 290", k_done);
    end
    vectors++;
    if (chg_at_done !== exp_chg) begin
      errors++;
      $display("FAIL glider_chg: got %b want %b",
               chg_at_done, exp_chg);
    end
    load_array(1'b1);
    run_frame(100, 1'b1, 1'b0);
    vectors++;
    if (chg_at_done !== exp_chg) begin
      errors++;
      $display("FAIL still_chg: got %b want %b",
               chg_at_done, exp_chg);
    end
    vectors++;
    if (frame_changed !== exp_chg) begin
      errors++;
      $display("FAIL chg_held: got %b want %b",
               frame_changed, exp_chg);
    end
    vectors++;
    if (n_steps != 1) begin
      errors++;
      $display("FAIL still_steps: got %0d want 1", n_steps);
    end
  endtask

  task automatic test_start_ignored();
    cell_t e, o;
    do_reset();
    load_array(1'b0);
    push_expected();
    run_frame(100, 1'b0, 1'b1);
    vectors++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL extra_starts: got %0d done want 1", n_done);
    end
    vectors++;
    if (busy_late) begin
      errors++;
      $display("FAIL done_start: got busy 1 want 0");
    end
    vectors++;
    if (k_done != 289) begin
      errors++;
      $display("FAIL busy_restart: got %0d want 289", k_done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL busy_cell: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    cell_t e, o;
    int    steps_seen;
    bit    hit;
    do_reset();
    load_array(1'b0);
    steps_seen = 0;
    hit = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      if (step === 1'b1) steps_seen++;
      if (out_valid === 1'b1 && out_row == 4'd7 && out_col == 4'd5)
        hit = 1;
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_row7: got timeout want row 7");
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, out_valid, step, out_row, out_col} !== 11'h0) begin
      errors++;
      $display("FAIL abort_idle: got %h want 0",
               {busy, out_valid, step, out_row, out_col});
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (step === 1'b1) steps_seen++;
    end
    vectors++;
    if (steps_seen != 0) begin
      errors++;
      $display("FAIL abort_step: got %0d want 0", steps_seen);
    end
    push_expected();
    run_frame(100, 1'b0, 1'b0);
    vectors++;
    if (k_first != 3) begin
      errors++;
      $display("FAIL refetch_lat: got %0d want 3", k_first);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL refetch_cell: got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    auto_step = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      cur[r] = 16'h0;
      prv[r] = 16'h0;
    end
    test_reset();
    test_glider();
    test_random_ready();
    test_auto_step();
    test_start_ignored();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
